mmcme2_drp_responder: RTL and testbench

MMCME2_DRP_RESPONDER -- requirements
Module: mmcme2_drp_responder

---
 rtl/mmcme2_drp_responder_pkg.sv | 17 +
 rtl/mmcme2_drp_responder_lock.sv | 29 ++
 rtl/mmcme2_drp_responder.sv | 131 +++++++++++++
 tb/tb_mmcme2_drp_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcme2_drp_responder_pkg.sv
// Shared types and constants for the MMCME2 DRP responder model.
// Holds the FSM encoding, default DRP widths and counter bounds.
package mmcme2_drp_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } drp_state_t;

    localparam int DRP_ADDR_W      = 7;
    localparam int DRP_DATA_W      = 16;
    localparam int RDY_LATENCY_MAX = 15;
    localparam int LAT_W           = 4;
    localparam int LOCK_CNT_W      = 16;

endpackage

// File: rtl/mmcme2_drp_responder_lock.sv
// Modelled MMCM lock timer: LOCKED rises LOCK_DELAY cycles after
// RST_MMCM falls; any reassertion before lock restarts the count.
module mmcm_lock_model
    import mmcme2_drp_responder_pkg::*;
#(
    parameter int LOCK_DELAY = 64
) (
    input  logic CLKIN,
    input  logic RST,
    input  logic RST_MMCM,
    output logic LOCKED
);

    logic [LOCK_CNT_W-1:0] lock_cnt;

    // Count while the MMCM is out of reset; flag lock on the final count.
    always_ff @(posedge CLKIN) begin
        if (RST || RST_MMCM) begin
            lock_cnt <= '0;
            LOCKED   <= 1'b0;
        end else if (!LOCKED) begin
            lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
            if (lock_cnt == LOCK_CNT_W'(LOCK_DELAY - 1)) begin
                LOCKED <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmcme2_drp_responder.sv
// DRP slave model of an MMCME2: register array with fixed response
// latency, busy rejection, unreset-write flag and lock model.
module mmcme2_drp_responder
    import mmcme2_drp_responder_pkg::*;
#(
    parameter int ADDR_W      = DRP_ADDR_W,
    parameter int DATA_W      = DRP_DATA_W,
    parameter int RDY_LATENCY = 3,
    parameter int LOCK_DELAY  = 64
) (
    input  logic              CLKIN,
    input  logic              RST,
    input  logic              DEN,
    input  logic              DWE,
    input  logic [ADDR_W-1:0] DADDR,
    input  logic [DATA_W-1:0] DI,
    input  logic              RST_MMCM,
    output logic [DATA_W-1:0] DO,
    output logic              DRDY,
    output logic              LOCKED,
    output logic              BUSY_ERR,
    output logic              UNRST_ERR
);

    localparam int DEPTH = 2 ** ADDR_W;

    drp_state_t        state;
    drp_state_t        state_next;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              cap_we;
    logic [DATA_W-1:0] mem [DEPTH];

    logic accept;
    logic resp_write;

    assign accept     = (state == S_IDLE) && DEN;
    assign resp_write = (state == S_RESP) && cap_we;

    // State register.
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: WAIT leaves once the counter is about to hit zero.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (DEN) begin
                    state_next = (RDY_LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt == LAT_W'(1)) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Response outputs: DO only carries read data during DRDY.
    always_comb begin
        DRDY = 1'b0;
        DO   = '0;
        if ((state == S_RESP) && !RST) begin
            DRDY = 1'b1;
            if (!cap_we) begin
                DO = mem[cap_addr];
            end
        end
    end

    // Transaction capture and latency counter.
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            lat_cnt  <= '0;
            cap_addr <= '0;
            cap_data <= '0;
            cap_we   <= 1'b0;
        end else if (accept) begin
            lat_cnt  <= LAT_W'(RDY_LATENCY - 1);
            cap_addr <= DADDR;
            cap_data <= DI;
            cap_we   <= DWE;
        end else if (state == S_WAIT) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
        end
    end

    // Register array: written on the response cycle of a write.
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (resp_write) begin
            mem[cap_addr] <= cap_data;
        end
    end

    // Error flags: busy pulse for rejected DEN, sticky unreset write.
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            BUSY_ERR  <= 1'b0;
            UNRST_ERR <= 1'b0;
        end else begin
            BUSY_ERR <= DEN && (state != S_IDLE);
            if (resp_write && !RST_MMCM) begin
                UNRST_ERR <= 1'b1;
            end
        end
    end

    mmcm_lock_model #(
        .LOCK_DELAY(LOCK_DELAY)
    ) u_lock (
        .CLKIN   (CLKIN),
        .RST     (RST),
        .RST_MMCM(RST_MMCM),
        .LOCKED  (LOCKED)
    );

endmodule

// File: tb/tb_mmcme2_drp_responder.sv
// Directed bench for mmcme2_drp_responder: table of DRP transactions
// plus hand sequences for busy, back-to-back, lock, unreset and abort.
module tb_mmcme2_drp_responder;

    logic        CLKIN = 1'b0;
    logic        RST;
    logic        DEN;
    logic        DWE;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic        RST_MMCM;
    logic [15:0] DO;
    logic        DRDY;
    logic        LOCKED;
    logic        BUSY_ERR;
    logic        UNRST_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_do;
    } vec_t;

    vec_t vecs [9];

    mmcme2_drp_responder #(
        .ADDR_W     (7),
        .DATA_W     (16),
        .RDY_LATENCY(3),
        .LOCK_DELAY (64)
    ) dut (
        .CLKIN    (CLKIN),
        .RST      (RST),
        .DEN      (DEN),
        .DWE      (DWE),
        .DADDR    (DADDR),
        .DI       (DI),
        .RST_MMCM (RST_MMCM),
        .DO       (DO),
        .DRDY     (DRDY),
        .LOCKED   (LOCKED),
        .BUSY_ERR (BUSY_ERR),
        .UNRST_ERR(UNRST_ERR)
    );

    always #5 CLKIN = ~CLKIN;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One DRP transaction; returns DEN->DRDY latency (-1 on timeout).
    task automatic txn(input logic we, input logic [6:0] a,
                       input logic [15:0] d, output int lat,
                       output logic [15:0] dout);
        lat  = -1;
        dout = 'x;
        DEN = 1'b1; DWE = we; DADDR = a; DI = d;
        tick();
        DEN = 1'b0; DWE = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (DRDY) begin
                lat  = k;
                dout = DO;
                break;
            end
            tick();
        end
        tick();
    endtask

    initial begin
        int          lat;
        logic [15:0] dout;
        logic        seen;

        vecs[0] = '{1'b1, 7'h08, 16'h1041, 16'h0000};
        vecs[1] = '{1'b0, 7'h08, 16'h0000, 16'h1041};
        vecs[2] = '{1'b1, 7'h7F, 16'hFFFF, 16'h0000};
        vecs[3] = '{1'b1, 7'h00, 16'hA5A5, 16'h0000};
        vecs[4] = '{1'b0, 7'h7F, 16'h0000, 16'hFFFF};
        vecs[5] = '{1'b0, 7'h00, 16'h0000, 16'hA5A5};
        vecs[6] = '{1'b0, 7'h05, 16'h0000, 16'h0000};
        vecs[7] = '{1'b1, 7'h08, 16'h0000, 16'h0000};
        vecs[8] = '{1'b0, 7'h08, 16'h0000, 16'h0000};

        RST = 1'b1; DEN = 1'b0; DWE = 1'b0;
        DADDR = '0; DI = '0; RST_MMCM = 1'b1;
        repeat (3) tick();
        check("rst_drdy", 32'(DRDY), 32'd0);
        check("rst_do", 32'(DO), 32'd0);
        check("rst_locked", 32'(LOCKED), 32'd0);
        check("rst_busy", 32'(BUSY_ERR), 32'd0);
        check("rst_unrst", 32'(UNRST_ERR), 32'd0);
        RST = 1'b0;
        tick();

        // Table: writes and reads with the MMCM held in reset.
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].data, lat, dout);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_do", i), 32'(dout), 32'(vecs[i].exp_do));
            seen |= BUSY_ERR;
        end
        check("tbl_unrst", 32'(UNRST_ERR), 32'd0);
        check("tbl_busy", 32'(seen), 32'd0);

        // Busy: DEN at t and t+1.
        DEN = 1'b1; DWE = 1'b0; DADDR = 7'h7F;
        tick();
        DADDR = 7'h00;
        check("busy_t1_drdy", 32'(DRDY), 32'd0);
        check("busy_t1_err", 32'(BUSY_ERR), 32'd0);
        tick();
        DEN = 1'b0;
        check("busy_t2_err", 32'(BUSY_ERR), 32'd1);
        check("busy_t2_drdy", 32'(DRDY), 32'd0);
        check("busy_t2_do", 32'(DO), 32'd0);
        tick();
        check("busy_t3_drdy", 32'(DRDY), 32'd1);
        check("busy_t3_do", 32'(DO), 32'hFFFF);
        check("busy_t3_err", 32'(BUSY_ERR), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen |= DRDY;
        end
        check("busy_extra_drdy", 32'(seen), 32'd0);

        // Back-to-back: DEN at t and t+4.
        seen = 1'b0;
        DEN = 1'b1; DADDR = 7'h00;
        tick();
        DEN = 1'b0;
        seen |= BUSY_ERR;
        tick();
        seen |= BUSY_ERR;
        tick();
        check("b2b_t3_drdy", 32'(DRDY), 32'd1);
        check("b2b_t3_do", 32'(DO), 32'hA5A5);
        seen |= BUSY_ERR;
        tick();
        DEN = 1'b1; DADDR = 7'h7F;
        seen |= BUSY_ERR;
        tick();
        DEN = 1'b0;
        seen |= BUSY_ERR;
        tick();
        seen |= BUSY_ERR;
        check("b2b_t6_drdy", 32'(DRDY), 32'd0);
        tick();
        check("b2b_t7_drdy", 32'(DRDY), 32'd1);
        check("b2b_t7_do", 32'(DO), 32'hFFFF);
        seen |= BUSY_ERR;
        tick();
        seen |= BUSY_ERR;
        check("b2b_busy", 32'(seen), 32'd0);

        // Unreset write.
        RST_MMCM = 1'b0;
        txn(1'b1, 7'h14, 16'h00C3, lat, dout);
        check("unrst_lat", 32'(lat), 32'd3);
        check("unrst_set", 32'(UNRST_ERR), 32'd1);
        txn(1'b0, 7'h14, 16'h0000, lat, dout);
        check("unrst_rd", 32'(dout), 32'h00C3);
        check("unrst_hold", 32'(UNRST_ERR), 32'd1);
        RST = 1'b1;
        RST_MMCM = 1'b1;
        tick();
        RST = 1'b0;
        check("unrst_clr", 32'(UNRST_ERR), 32'd0);
        check("unrst_rst_locked", 32'(LOCKED), 32'd0);
        repeat (3) tick();

        // Lock: plain fall, then a restart pulse at t+30.
        RST_MMCM = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 63) check("lock_63", 32'(LOCKED), 32'd0);
            if (k == 64) check("lock_64", 32'(LOCKED), 32'd1);
        end
        RST_MMCM = 1'b1;
        repeat (3) tick();
        check("lock_drop", 32'(LOCKED), 32'd0);
        RST_MMCM = 1'b0;
        repeat (30) tick();
        RST_MMCM = 1'b1;
        tick();
        RST_MMCM = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 33) check("relock_33", 32'(LOCKED), 32'd0);
            if (k == 63) check("relock_63", 32'(LOCKED), 32'd0);
            if (k == 64) check("relock_64", 32'(LOCKED), 32'd1);
        end

        // Abort: RST one cycle after a write DEN.
        RST_MMCM = 1'b1;
        tick();
        DEN = 1'b1; DWE = 1'b1; DADDR = 7'h28; DI = 16'hBEEF;
        tick();
        DEN = 1'b0; DWE = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen |= DRDY;
            tick();
        end
        check("abort_drdy", 32'(seen), 32'd0);
        txn(1'b0, 7'h28, 16'h0000, lat, dout);
        check("abort_lat", 32'(lat), 32'd3);
        check("abort_rd", 32'(dout), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
